// File: rtl/gan_pkg.sv
// Shared Q8.8 constants and the activation-stage state type for the generator layers.
package gan_pkg;

  localparam int Q_DW          = 16;
  localparam int Q_FRAC        = 8;
  localparam int LEAKY_ALPHA_Q = 51;  // 0.2 in Q8.8

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } act_state_t;

endpackage

// File: rtl/leaky_relu_q88.sv
// Single-element Q8.8 activation: LeakyReLU when LEAKY_RELU_EN is defined, plain ReLU otherwise.
module leaky_relu_q88
  import gan_pkg::*;
(
  input  logic signed [Q_DW-1:0] x,
  output logic signed [Q_DW-1:0] y
);

`ifdef LEAKY_RELU_EN
  logic signed [31:0] prod_s;
  logic signed [31:0] shift_s;

  // Negative branch scales by alpha with floor rounding; magnitude never grows, so truncation is safe.
  always_comb begin
    prod_s  = 32'(x) * LEAKY_ALPHA_Q;
    shift_s = prod_s >>> Q_FRAC;
    if (x[Q_DW-1]) begin
      y = shift_s[Q_DW-1:0];
    end else begin
      y = x;
    end
  end
`else
  // Negative inputs clamp to zero.
  always_comb begin
    if (x[Q_DW-1]) begin
      y = '0;
    end else begin
      y = x;
    end
  end
`endif

endmodule

// File: rtl/layer1_activation.sv
// Sequential activation stage: captures the pre-activation vector on start, activates LANES
// elements per cycle, then pulses done. Negative-branch behaviour selected by LEAKY_RELU_EN.
module layer1_activation
  import gan_pkg::*;
#(
  parameter int N     = 256,
  parameter int DW    = 16,
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW*N-1:0] flat_input_flat,
  output logic [DW*N-1:0] flat_output_flat,
  output logic            busy,
  output logic            done
);

  localparam int CHUNKS = N / LANES;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  act_state_t         state_r;
  act_state_t         state_s;
  logic [IDX_W-1:0]   idx_r;
  logic [DW*N-1:0]    bank_r;
  logic [DW*N-1:0]    out_r;
  logic               busy_r;
  logic               done_r;
  logic signed [DW-1:0] lane_in_s  [LANES];
  logic signed [DW-1:0] lane_out_s [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_in_s[j] = bank_r[(int'(idx_r) * LANES + j) * DW +: DW];

    leaky_relu_q88 u_act (
      .x (lane_in_s[j]),
      .y (lane_out_s[j])
    );
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counter, input bank and output register; done is registered one cycle after DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      bank_r  <= '0;
      out_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE) || (state_r == DONE);
      done_r  <= (state_r == DONE);
      if ((state_r == IDLE) && start) begin
        bank_r <= flat_input_flat;
        idx_r  <= '0;
      end else if (state_r == RUN) begin
        idx_r <= idx_r + IDX_W'(1);
        for (int j = 0; j < LANES; j++) begin
          out_r[(int'(idx_r) * LANES + j) * DW +: DW] <= lane_out_s[j];
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign flat_output_flat = out_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule
